// File: rtl/beep_pkg.sv
// Shared constants and helpers for the buzzer arbiter: FSM encodings, requester count,
// idle grant code and small priority/count selection functions.
package beep_pkg;

    localparam int unsigned NREQ = 3;
    localparam logic [1:0] GRANT_NONE = 2'd3;

    typedef logic [1:0] beep_state_t;
    localparam beep_state_t StIdle = 2'd0;
    localparam beep_state_t StOn   = 2'd1;
    localparam beep_state_t StOff  = 2'd2;
    localparam beep_state_t StGap  = 2'd3;

    // Lowest set index wins; GRANT_NONE when nothing is requesting.
    function automatic logic [1:0] prio_pick(input logic [NREQ-1:0] r);
        logic [1:0] p;
        p = GRANT_NONE;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (r[k]) p = k[1:0];
        end
        return p;
    endfunction

    function automatic logic [3:0] cnt_of(input logic [4*NREQ-1:0] c, input logic [1:0] i);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (i == k[1:0]) r = c[4*k +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/beep_timebase.sv
// Phase timer: a 1 ms tick prescaler feeding a ms counter, both cleared synchronously,
// with a flag marking the final clock of a phase of len_i ms.
module beep_timebase #(
    parameter int unsigned TickDiv = 25000,
    parameter int unsigned MsW     = 9
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clr_i,
    input  logic [MsW-1:0] len_i,
    output logic           done_o
);

    localparam int unsigned PresW = (TickDiv > 1) ? $clog2(TickDiv) : 1;

    logic [PresW-1:0] presc_q, presc_d;
    logic [MsW-1:0]   ms_q, ms_d;
    logic             tick_end;

    assign tick_end = (presc_q == PresW'(TickDiv - 1));
    assign done_o   = tick_end && (ms_q == len_i - MsW'(1));

    always_comb begin
        presc_d = presc_q + PresW'(1);
        ms_d    = ms_q;
        if (clr_i) begin
            presc_d = '0;
            ms_d    = '0;
        end else if (tick_end) begin
            presc_d = '0;
            ms_d    = ms_q + MsW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            ms_q    <= '0;
        end else begin
            presc_q <= presc_d;
            ms_q    <= ms_d;
        end
    end

endmodule

// File: rtl/beep_arbiter.sv
// Buzzer arbiter: fixed-priority sharing of one buzzer among three requesters, with
// requester 0 able to preempt; plays N tone bursts, off periods and a closing guard gap.
module beep_arbiter
    import beep_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 25000,
    parameter int unsigned TONE_HALF = 12500,
    parameter int unsigned ON_MS     = 100,
    parameter int unsigned OFF_MS    = 100,
    parameter int unsigned GAP_MS    = 300
) (
    input  logic              ext_clk_25m,
    input  logic              ext_rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_cnt,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   abort,
    output logic              busy,
    output logic [1:0]        grant_id,
    output logic              beep
);

    localparam int unsigned MsMax = (ON_MS > OFF_MS) ?
                                    ((ON_MS > GAP_MS) ? ON_MS : GAP_MS) :
                                    ((OFF_MS > GAP_MS) ? OFF_MS : GAP_MS);
    localparam int unsigned MsW   = $clog2(MsMax + 1);
    localparam int unsigned ToneW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    beep_state_t      state_q, state_d;
    logic [3:0]       rem_q, rem_d;
    logic [ToneW-1:0] tone_q, tone_d;
    logic [NREQ-1:0]  ack_q, ack_d, abort_q, abort_d;
    logic             busy_q, busy_d, beep_q, beep_d;
    logic [1:0]       grant_q, grant_d;

    logic [MsW-1:0]   len;
    logic             phase_done, restart, preempt;
    logic [1:0]       pick;
    logic [3:0]       pick_cnt, cnt0;

    assign pick     = prio_pick(req);
    assign pick_cnt = cnt_of(req_cnt, pick);
    assign cnt0     = req_cnt[3:0];
    assign preempt  = req[0] && (state_q != StIdle) && (grant_q != 2'd0);

    always_comb begin
        case (state_q)
            StOff:   len = MsW'(OFF_MS);
            StGap:   len = MsW'(GAP_MS);
            default: len = MsW'(ON_MS);
        endcase
    end

    beep_timebase #(
        .TickDiv (TICK_DIV),
        .MsW     (MsW)
    ) u_timebase (
        .clk_i  (ext_clk_25m),
        .rst_ni (ext_rst_n),
        .clr_i  (restart),
        .len_i  (len),
        .done_o (phase_done)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        tone_d  = tone_q;
        ack_d   = '0;
        abort_d = '0;
        grant_d = grant_q;
        beep_d  = beep_q;
        // Preemption outranks any phase-end transition in the same cycle.
        if (preempt) begin
            abort_d[grant_q] = 1'b1;
            ack_d[0]         = 1'b1;
            rem_d            = cnt0;
            tone_d           = '0;
            if (cnt0 != 4'd0) begin
                state_d = StOn;
                grant_d = 2'd0;
                beep_d  = 1'b1;
            end else begin
                state_d = StIdle;
                grant_d = GRANT_NONE;
                beep_d  = 1'b0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (pick != GRANT_NONE) begin
                        ack_d[pick] = 1'b1;
                        rem_d       = pick_cnt;
                        if (pick_cnt != 4'd0) begin
                            state_d = StOn;
                            grant_d = pick;
                            beep_d  = 1'b1;
                            tone_d  = '0;
                        end
                    end
                end
                StOn: begin
                    if (phase_done) begin
                        beep_d  = 1'b0;
                        rem_d   = rem_q - 4'd1;
                        state_d = StOff;
                    end else if (tone_q == ToneW'(TONE_HALF - 1)) begin
                        tone_d = '0;
                        beep_d = ~beep_q;
                    end else begin
                        tone_d = tone_q + ToneW'(1);
                    end
                end
                StOff: begin
                    if (phase_done) begin
                        if (rem_q != 4'd0) begin
                            state_d = StOn;
                            beep_d  = 1'b1;
                            tone_d  = '0;
                        end else begin
                            state_d = StGap;
                        end
                    end
                end
                StGap: begin
                    if (phase_done) begin
                        state_d = StIdle;
                        grant_d = GRANT_NONE;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        busy_d  = (state_d != StIdle);
        // Idle holds the timebase cleared so every phase starts from zero.
        restart = preempt || (state_d != state_q) || (state_q == StIdle);
    end

    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            state_q <= StIdle;
            rem_q   <= '0;
            tone_q  <= '0;
            ack_q   <= '0;
            abort_q <= '0;
            busy_q  <= 1'b0;
            grant_q <= GRANT_NONE;
            beep_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tone_q  <= tone_d;
            ack_q   <= ack_d;
            abort_q <= abort_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
            beep_q  <= beep_d;
        end
    end

    assign ack      = ack_q;
    assign abort    = abort_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;
    assign beep     = beep_q;

endmodule

// File: tb/tb_beep_arbiter.sv
// Scoreboard bench for beep_arbiter: stimulus queues expected ack/abort pulses and busy
// periods; a negedge monitor pops and compares whenever the DUT presents them.
module tb_beep_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [11:0] req_cnt = '0;
    logic [2:0]  ack, abort;
    logic        busy, beep;
    logic [1:0]  grant_id;

    logic [2:0]  auto_drop = '0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [2:0] ack;
        logic [2:0] abort;
        logic [1:0] grant;
        logic       busy;
        logic       beep;
        int         cyc;
    } ev_t;

    typedef struct {
        int         len;
        int         high;
        int         rises;
        logic [1:0] grant;
    } run_t;

    ev_t  evq[$];
    run_t runq[$];

    beep_arbiter #(
        .TICK_DIV  (10),
        .TONE_HALF (2),
        .ON_MS     (3),
        .OFF_MS    (2),
        .GAP_MS    (4)
    ) dut (
        .ext_clk_25m (clk),
        .ext_rst_n   (rst_n),
        .req         (req),
        .req_cnt     (req_cnt),
        .ack         (ack),
        .abort       (abort),
        .busy        (busy),
        .grant_id    (grant_id),
        .beep        (beep)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Requesters drop their line on seeing their own ack.
    initial forever begin
        @(negedge clk);
        if ((ack & auto_drop) != 3'b000) req = req & ~(ack & auto_drop);
    end

    // Monitor: pulse events and busy periods.
    initial begin
        ev_t        e;
        run_t       r;
        int         run_len = 0, run_high = 0, run_rises = 0;
        logic [1:0] run_grant = 2'd3;
        logic       prev_beep = 1'b0, prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (ack !== 3'b000 || abort !== 3'b000) begin
                checks++;
                if (evq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: ack=%b abort=%b at cycle %0d, none expected",
                             ack, abort, cyc);
                end else begin
                    e = evq.pop_front();
                    if (ack !== e.ack || abort !== e.abort || grant_id !== e.grant ||
                        busy !== e.busy || beep !== e.beep || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL pulse_event: got ack=%b abort=%b grant=%0d busy=%b beep=%b cyc=%0d, want ack=%b abort=%b grant=%0d busy=%b beep=%b cyc=%0d",
                                 ack, abort, grant_id, busy, beep, cyc,
                                 e.ack, e.abort, e.grant, e.busy, e.beep, e.cyc);
                    end
                end
            end
            if (busy === 1'b1) begin
                run_len++;
                if (beep === 1'b1) run_high++;
                if (beep === 1'b1 && prev_beep !== 1'b1) run_rises++;
                run_grant = grant_id;
            end else if (prev_busy === 1'b1) begin
                checks++;
                if (runq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_busy: run of %0d cycles at cycle %0d, none expected",
                             run_len, cyc);
                end else begin
                    r = runq.pop_front();
                    if (run_len != r.len || run_high != r.high || run_rises != r.rises ||
                        run_grant !== r.grant) begin
                        errors++;
                        $display("FAIL busy_run: got len=%0d high=%0d rises=%0d grant=%0d, want len=%0d high=%0d rises=%0d grant=%0d",
                                 run_len, run_high, run_rises, run_grant,
                                 r.len, r.high, r.rises, r.grant);
                    end
                end
                run_len = 0;
                run_high = 0;
                run_rises = 0;
            end
            prev_beep = beep;
            prev_busy = busy;
        end
    end

    task automatic push_ev(input logic [2:0] a, input logic [2:0] ab, input logic [1:0] g,
                           input logic b, input logic bp, input int c);
        ev_t e;
        e.ack = a; e.abort = ab; e.grant = g; e.busy = b; e.beep = bp; e.cyc = c;
        evq.push_back(e);
    endtask

    task automatic push_run(input int len, input int high, input int rises, input logic [1:0] g);
        run_t r;
        r.len = len; r.high = high; r.rises = rises; r.grant = g;
        runq.push_back(r);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_quiet(input string name, input int max);
        int n = 0;
        while ((busy !== 1'b0 || evq.size() != 0 || runq.size() != 0) && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= max) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy=%b pending_events=%0d pending_runs=%0d, want all idle",
                     name, busy, evq.size(), runq.size());
            evq.delete();
            runq.delete();
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    initial begin
        int t;
        int bad;

        repeat (3) @(posedge clk);
        #1;
        check1("reset_beep", {3'b0, beep}, 4'h0);
        check1("reset_busy", {3'b0, busy}, 4'h0);
        check1("reset_ack", {1'b0, ack}, 4'h0);
        check1("reset_abort", {1'b0, abort}, 4'h0);
        check1("reset_grant", {2'b0, grant_id}, 4'h3);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: single requester 2, two beeps.
        t = cyc;
        req_cnt = 12'h200; auto_drop = 3'b111; req = 3'b100;
        push_ev(3'b100, 3'b000, 2'd2, 1'b1, 1'b1, t + 1);
        push_run(140, 32, 16, 2'd2);
        wait_quiet("t1", 400);

        // 2: simultaneous 1 and 2; 1 wins, 2 served after the gap.
        t = cyc;
        req_cnt = 12'h110; req = 3'b110;
        push_ev(3'b010, 3'b000, 2'd1, 1'b1, 1'b1, t + 1);
        push_ev(3'b100, 3'b000, 2'd2, 1'b1, 1'b1, t + 92);
        push_run(90, 16, 8, 2'd1);
        push_run(90, 16, 8, 2'd2);
        wait_quiet("t2", 400);

        // 3: requester 0 preempts mid second burst of requester 2.
        t = cyc;
        req_cnt = 12'h300; req = 3'b100;
        push_ev(3'b100, 3'b000, 2'd2, 1'b1, 1'b1, t + 1);
        push_run(155, 40, 20, 2'd0);
        wait_cyc(t + 65);
        req_cnt = 12'h301; req = req | 3'b001;
        push_ev(3'b001, 3'b100, 2'd0, 1'b1, 1'b1, t + 66);
        wait_quiet("t3", 400);

        // 4: zero count is acked but silent.
        t = cyc;
        req_cnt = 12'h000; req = 3'b010;
        push_ev(3'b010, 3'b000, 2'd3, 1'b0, 1'b0, t + 1);
        wait_quiet("t4", 100);

        // 5: asynchronous reset during the first ON burst.
        t = cyc;
        req_cnt = 12'h200; req = 3'b100;
        push_ev(3'b100, 3'b000, 2'd2, 1'b1, 1'b1, t + 1);
        push_run(10, 6, 3, 2'd2);
        wait_cyc(t + 11);
        #3;
        rst_n = 1'b0;
        #1;
        check1("async_rst_beep", {3'b0, beep}, 4'h0);
        check1("async_rst_busy", {3'b0, busy}, 4'h0);
        check1("async_rst_ack", {1'b0, ack}, 4'h0);
        check1("async_rst_grant", {2'b0, grant_id}, 4'h3);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (beep !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_reset_silent: beep high on %0d cycles, want 0", bad);
        end
        wait_quiet("t5", 100);

        // 6: requester 0 held through its own gap is re-acked only from idle.
        t = cyc;
        req_cnt = 12'h001; auto_drop = 3'b110; req = 3'b001;
        push_ev(3'b001, 3'b000, 2'd0, 1'b1, 1'b1, t + 1);
        push_ev(3'b001, 3'b000, 2'd0, 1'b1, 1'b1, t + 92);
        push_run(90, 16, 8, 2'd0);
        push_run(140, 32, 16, 2'd0);
        wait_cyc(t + 50);
        req_cnt = 12'h002; auto_drop = 3'b111;
        wait_quiet("t6", 500);

        checks++;
        if (evq.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: %0d pending, want 0", evq.size());
        end
        checks++;
        if (runq.size() != 0) begin
            errors++;
            $display("FAIL leftover_runs: %0d pending, want 0", runq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
